// File: rtl/pipeline_divide.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_divide
//  Description : Fully pipelined unsigned restoring divider. One quotient bit
//                is resolved per registered stage (MSB first). Accepts one
//                dividend/divisor pair per clock; quotient, remainder and a
//                divide-by-zero flag retire N+1 clocks later.
//  Revision    : 1.0  initial release
// ============================================================================
module pipeline_divide #(
  parameter int N = 8,  // dividend/quotient width and stage count (N >= 2)
  parameter int M = 4   // divisor/remainder width
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] dividend,
  input  logic [M-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [M-1:0] remainder,
  output logic         div_zero,
  output logic         ready
);

  // Stage registers, one packed element per stage.
  logic [N-1:0]          valid_q,   valid_d;
  logic [N-1:0]          dz_q,      dz_d;
  logic [N-1:0][M-1:0]   divisor_q, divisor_d;
  logic [N-1:0][N-1:0]   shift_q,   shift_d;
  logic [N-1:0][M:0]     rem_q,     rem_d;
  logic [N-1:0][N-1:0]   quo_q,     quo_d;

  // Values each stage works on: the inputs for stage 0, the previous
  // stage's registers otherwise.
  logic [N-1:0]          in_valid;
  logic [N-1:0]          in_dz;
  logic [N-1:0][M-1:0]   in_divisor;
  logic [N-1:0][N-1:0]   in_shift;
  logic [N-1:0][M:0]     in_rem;
  logic [N-1:0][N-1:0]   in_quo;

  // Bits that are carried for uniformity but never read: the remainder MSB
  // (always shifted out) and the quotient MSB (shifted out before retire).
  logic [N-1:0]          stage_unused;

  for (genvar k = 0; k < N; k++) begin : g_stage
    logic [M:0] trial;
    logic       take;

    if (k == 0) begin : g_head
      assign in_valid[k]   = en;
      assign in_dz[k]      = (divisor == '0);
      assign in_divisor[k] = divisor;
      assign in_shift[k]   = dividend;
      assign in_rem[k]     = '0;
      assign in_quo[k]     = '0;
    end else begin : g_body
      assign in_valid[k]   = valid_q[k-1];
      assign in_dz[k]      = dz_q[k-1];
      assign in_divisor[k] = divisor_q[k-1];
      assign in_shift[k]   = shift_q[k-1];
      assign in_rem[k]     = rem_q[k-1];
      assign in_quo[k]     = quo_q[k-1];
    end

    // Shift the next dividend bit into the partial remainder and try a
    // subtract at M+1 bits so the largest trial value cannot overflow.
    assign trial        = {in_rem[k][M-1:0], in_shift[k][N-1]};
    assign take         = (trial >= {1'b0, in_divisor[k]});
    assign rem_d[k]     = take ? (trial - {1'b0, in_divisor[k]}) : trial;
    assign quo_d[k]     = {in_quo[k][N-2:0], take};
    assign shift_d[k]   = {in_shift[k][N-2:0], 1'b0};
    assign valid_d[k]   = in_valid[k];
    assign dz_d[k]      = in_dz[k];
    assign divisor_d[k] = in_divisor[k];

    assign stage_unused[k] = in_rem[k][M] ^ in_quo[k][N-1];
  end

  logic unused_sink;
  assign unused_sink = ^{stage_unused, rem_q[N-1][M], shift_q[N-1], divisor_q[N-1]};

  // Stage register bank; data clears on reset together with the valid bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= '0;
      dz_q      <= '0;
      divisor_q <= '0;
      shift_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      dz_q      <= dz_d;
      divisor_q <= divisor_d;
      shift_q   <= shift_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
    end
  end

  logic         ready_q,     ready_d;
  logic [N-1:0] quotient_q,  quotient_d;
  logic [M-1:0] remainder_q, remainder_d;
  logic         div_zero_q,  div_zero_d;

  // Retire stage: results load only when the last stage is valid, so they
  // hold while idle; divide-by-zero forces all-ones quotient, zero remainder.
  always_comb begin
    ready_d     = valid_q[N-1];
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    if (valid_q[N-1]) begin
      div_zero_d = dz_q[N-1];
      if (dz_q[N-1]) begin
        quotient_d  = '1;
        remainder_d = '0;
      end else begin
        quotient_d  = quo_q[N-1];
        remainder_d = rem_q[N-1][M-1:0];
      end
    end
  end

  // Output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      ready_q     <= ready_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
    end
  end

  assign ready     = ready_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_divide.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_pipeline_divide
//  Description : Scoreboard bench for pipeline_divide (N=8/M=4 and N=16/M=8).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipeline_divide;

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    logic        dz;
    int unsigned cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  int unsigned cyc = 0;

  // 8/4 instance
  logic        en_a;
  logic [7:0]  dividend_a;
  logic [3:0]  divisor_a;
  logic [7:0]  quotient_a;
  logic [3:0]  remainder_a;
  logic        div_zero_a, ready_a;

  // 16/8 instance
  logic        en_b;
  logic [15:0] dividend_b;
  logic [7:0]  divisor_b;
  logic [15:0] quotient_b;
  logic [7:0]  remainder_b;
  logic        div_zero_b, ready_b;

  int n_compared   = 0;
  int n_mismatched = 0;

  exp_t exp_a[$];
  exp_t exp_b[$];
  exp_t ea, eb;

  pipeline_divide #(.N(8), .M(4)) u_dut_a (
    .clk(clk), .rst(rst), .en(en_a), .dividend(dividend_a), .divisor(divisor_a),
    .quotient(quotient_a), .remainder(remainder_a), .div_zero(div_zero_a), .ready(ready_a)
  );

  pipeline_divide #(.N(16), .M(8)) u_dut_b (
    .clk(clk), .rst(rst), .en(en_b), .dividend(dividend_b), .divisor(divisor_b),
    .quotient(quotient_b), .remainder(remainder_b), .div_zero(div_zero_b), .ready(ready_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_compared++;
    if (got !== want) begin
      n_mismatched++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic exp_t model_a(input logic [7:0] a, input logic [3:0] b);
    exp_t e;
    e.cyc = 0;
    if (b == 4'd0) begin
      e.q = 64'hFF; e.r = 64'd0; e.dz = 1'b1;
    end else begin
      e.q = 64'(a / b); e.r = 64'(a % b); e.dz = 1'b0;
    end
    return e;
  endfunction

  function automatic exp_t model_b(input logic [15:0] a, input logic [7:0] b);
    exp_t e;
    e.cyc = 0;
    if (b == 8'd0) begin
      e.q = 64'hFFFF; e.r = 64'd0; e.dz = 1'b1;
    end else begin
      e.q = 64'(a / b); e.r = 64'(a % b); e.dz = 1'b0;
    end
    return e;
  endfunction

  task automatic issue_a(input logic [7:0] a, input logic [3:0] b,
                         input logic [63:0] q, input logic [63:0] r, input logic dz);
    exp_t e;
    @(negedge clk);
    en_a = 1'b1; dividend_a = a; divisor_a = b;
    e.q = q; e.r = r; e.dz = dz; e.cyc = cyc;
    exp_a.push_back(e);
  endtask

  task automatic issue_b(input logic [15:0] a, input logic [7:0] b,
                         input logic [63:0] q, input logic [63:0] r, input logic dz);
    exp_t e;
    @(negedge clk);
    en_b = 1'b1; dividend_b = a; divisor_b = b;
    e.q = q; e.r = r; e.dz = dz; e.cyc = cyc;
    exp_b.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      en_a = 1'b0; en_b = 1'b0;
      dividend_a = 8'($urandom); divisor_a = 4'($urandom);
      dividend_b = 16'($urandom); divisor_b = 8'($urandom);
    end
  endtask

  // Retire monitor, instance A.
  always @(negedge clk) begin
    if (ready_a) begin
      if (exp_a.size() == 0) begin
        check("a_spurious_ready", 64'(ready_a), 64'd0);
      end else begin
        ea = exp_a.pop_front();
        check("a_quotient",  64'(quotient_a),  ea.q);
        check("a_remainder", 64'(remainder_a), ea.r);
        check("a_div_zero",  64'(div_zero_a),  64'(ea.dz));
        check("a_latency",   64'(cyc - ea.cyc), 64'd9);
      end
    end
  end

  // Retire monitor, instance B.
  always @(negedge clk) begin
    if (ready_b) begin
      if (exp_b.size() == 0) begin
        check("b_spurious_ready", 64'(ready_b), 64'd0);
      end else begin
        eb = exp_b.pop_front();
        check("b_quotient",  64'(quotient_b),  eb.q);
        check("b_remainder", 64'(remainder_b), eb.r);
        check("b_div_zero",  64'(div_zero_b),  64'(eb.dz));
        check("b_latency",   64'(cyc - eb.cyc), 64'd17);
      end
    end
  end

  // Global time bound.
  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation exceeded time bound, %0d pending a, %0d pending b",
             exp_a.size(), exp_b.size());
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    logic [7:0]  ra;
    logic [3:0]  rb;
    logic [15:0] rc;
    logic [7:0]  rd;

    rst = 1'b1;
    en_a = 1'b0; dividend_a = '0; divisor_a = '0;
    en_b = 1'b0; dividend_b = '0; divisor_b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_ready_a",     64'(ready_a),     64'd0);
    check("rst_quotient_a",  64'(quotient_a),  64'd0);
    check("rst_remainder_a", 64'(remainder_a), 64'd0);
    check("rst_div_zero_a",  64'(div_zero_a),  64'd0);
    check("rst_ready_b",     64'(ready_b),     64'd0);
    check("rst_quotient_b",  64'(quotient_b),  64'd0);

    // Single operation
    issue_a(8'd200, 4'd7, 64'd28, 64'd4, 1'b0);
    idle(12);

    // Outputs hold while idle
    check("hold_quotient_a",  64'(quotient_a),  64'd28);
    check("hold_remainder_a", 64'(remainder_a), 64'd4);
    check("hold_ready_a",     64'(ready_a),     64'd0);

    // Boundary operations back-to-back
    issue_a(8'd255, 4'd15, 64'd17,  64'd0, 1'b0);
    issue_a(8'd5,   4'd9,  64'd0,   64'd5, 1'b0);
    issue_a(8'd0,   4'd3,  64'd0,   64'd0, 1'b0);
    issue_a(8'd173, 4'd1,  64'd173, 64'd0, 1'b0);
    idle(12);

    // Divide by zero followed by a normal op
    issue_a(8'd100, 4'd0,  64'd255, 64'd0, 1'b1);
    issue_a(8'd100, 4'd10, 64'd10,  64'd0, 1'b0);
    idle(12);

    // Reset mid-flight: the three ops are discarded
    issue_a(8'd50, 4'd3, 64'd16, 64'd2, 1'b0);
    issue_a(8'd77, 4'd5, 64'd15, 64'd2, 1'b0);
    issue_a(8'd9,  4'd2, 64'd4,  64'd1, 1'b0);
    idle(1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_a.delete();
    exp_b.delete();
    check("midrst_ready_a", 64'(ready_a), 64'd0);
    idle(12);
    issue_a(8'd60, 4'd7, 64'd8, 64'd4, 1'b0);
    idle(12);

    // Wider instance
    issue_b(16'd65535, 8'd255, 64'd257, 64'd0, 1'b0);
    issue_b(16'd1000,  8'd3,   64'd333, 64'd1, 1'b0);
    issue_b(16'd4242,  8'd0,   64'hFFFF, 64'd0, 1'b1);
    idle(20);

    // Random regression, instance A
    for (int i = 0; i < 10000; i++) begin
      ra = 8'($urandom);
      rb = 4'($urandom);
      e  = model_a(ra, rb);
      issue_a(ra, rb, e.q, e.r, e.dz);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(12);

    // Random regression, instance B
    for (int i = 0; i < 300; i++) begin
      rc = 16'($urandom);
      rd = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
      e  = model_b(rc, rd);
      issue_b(rc, rd, e.q, e.r, e.dz);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(20);

    // Every accepted operation must have retired
    check("drain_pending_a", 64'(exp_a.size()), 64'd0);
    check("drain_pending_b", 64'(exp_b.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
`default_nettype wire
